adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
Round-robin controller that shares one combinational WIDTH-bit ripple adder between two requesters. It latches the winning requester's operands, drives them onto the shared adder, waits a programmable settle time, then captures the sum and carry and returns them with a per-requester done pulse. It sits between the switch/UI front-end logic and the five-bit ripple adder on the Basys-3 board.

Parameters:
WIDTH, 5, operand/sum width; must match the shared adder.
SETTLE_CYCLES, 1, clock cycles the adder inputs are held before the result is captured; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
req0  input  1  requester 0 transaction request (level).
a0_in  input  WIDTH  requester 0 operand A.
b0_in  input  WIDTH  requester 0 operand B.
req1  input  1  requester 1 transaction request (level).
a1_in  input  WIDTH  requester 1 operand A.
b1_in  input  WIDTH  requester 1 operand B.
add_a  output  WIDTH  operand A driven to the shared adder (registered).
add_b  output  WIDTH  operand B driven to the shared adder (registered).
add_s  input  WIDTH  sum returned from the shared adder.
add_cout  input  1  carry out returned from the shared adder.
ack0  output  1  one-cycle grant/acknowledge to requester 0.
ack1  output  1  one-cycle grant/acknowledge to requester 1.
done0  output  1  one-cycle result-valid pulse to requester 0.
done1  output  1  one-cycle result-valid pulse to requester 1.
sum_out  output  WIDTH  captured sum; held until the next capture.
cout_out  output  1  captured carry; held until the next capture.
busy  output  1  high while a transaction is in flight (state ADD).

Behaviour:
- Clock/reset: one clock (clk); rst is asynchronous and active-high. While rst is high: state=IDLE, prio=0, settle counter=0. All outputs are 0: add_a, add_b, ack0/1, done0/1, sum_out, cout_out, busy.
- All outputs are registered. ack and done are single-cycle pulses.
- State IDLE:
  - At a clock edge with req0|req1 high, the arbiter picks a winner. If only one request is high, that requester wins. If both are high, the winner is the requester indicated by prio.
  - At that same edge: add_a/add_b load the winner's a/b inputs; ack of the winner goes to 1; counter loads SETTLE_CYCLES-1; prio loads the index of the loser; state goes to ADD; busy goes to 1.
- State ADD:
  - ack returns to 0 on the first ADD edge.
  - If counter != 0, it decrements.
  - If counter == 0: sum_out<=add_s, cout_out<=add_cout; done of the granted requester<=1; state<=IDLE; busy<=0.
  - Requests are ignored in ADD. Requester inputs are ignored after the grant edge; the operands are those sampled at the grant edge.
- Latency: grant at edge k; done and result at edge k+SETTLE_CYCLES. The earliest next grant is edge k+SETTLE_CYCLES+1. Throughput is one transaction per SETTLE_CYCLES+1 cycles.
- Handshake:
  - req is level-sensitive, and each ack consumes exactly one transaction.
  - A requester that keeps req high after its ack issues a new request, which is evaluated in the next IDLE cycle.
  - Dropping req before ack withdraws the request without penalty.
- Fairness: with both requests held continuously, grants strictly alternate 0,1,0,1… The first grant after reset goes to requester 0.
- Arithmetic: the block does no arithmetic. sum_out/cout_out are exactly the adder's WIDTH-bit sum (modulo 2^WIDTH) and carry. Wrap-around, e.g. 31+1 giving 0 with carry 1, comes from the adder.
- add_a/add_b hold their last values in IDLE; they change only at a grant edge.
- Reset mid-ADD: the transaction is aborted, no done is issued, and all outputs clear. After release, the first grant favours requester 0.
- At most one ack and at most one done are high in any cycle. ack and done are never high in the same cycle.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately, busy=0, no ack/done pulses afterwards until a req arrives.
- Single request: SETTLE=1, req0=1, a0=13, b0=9 for one cycle -> ack0 one cycle after the sampling edge; done0 one cycle later with sum_out=22, cout_out=0; ack1/done1 stay 0.
- Overflow wrap: req1, a1=31, b1=1 -> done1 with sum_out=0, cout_out=1; a0=16, b0=16 via req0 -> sum_out=0, cout_out=1.
- Contention: after reset, req0 and req1 held high, a0=3/b0=4, a1=10/b1=20 -> acks in order 0,1,0,1; results 7,30,7,30; each done arrives SETTLE_CYCLES edges after its ack; busy toggles with period SETTLE+1.
- Operand stability: SETTLE=3, change a0_in from 5 to 20 one cycle after ack0 (b0=2) -> add_a stays 5; result sum_out=7.
- Reset mid-ADD: SETTLE=3, grant req1, assert rst one cycle after ack1, release, hold req0 and req1 -> no done1 for the aborted transaction; first post-reset grant goes to req0.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Two requesters share one combinational ripple adder. The winner of the
// round-robin arbitration has its operands registered onto the adder. After
// SETTLE_CYCLES clock edges the sum and carry are captured and returned with
// a one-cycle done pulse. All outputs are registered.
module adder_share_arbiter #(
    parameter int WIDTH         = 5,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0_in,
    input  logic [WIDTH-1:0] b0_in,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1_in,
    input  logic [WIDTH-1:0] b1_in,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    output logic             ack0,
    output logic             ack1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             busy
);

    // The settle counter counts down to zero. Loading SETTLE_CYCLES-1 places
    // the capture edge exactly SETTLE_CYCLES edges after the grant edge.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             gnt_q, gnt_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             busy_q, busy_d;
    logic             win;

    // Next-state logic: arbitration and grant in IDLE, settle countdown and
    // result capture in ADD. ack/done default low so they only ever pulse.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        win     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // A lone requester always wins; a tie goes to prio.
                    win     = (req0 && req1) ? prio_q : req1;
                    add_a_d = win ? a1_in : a0_in;
                    add_b_d = win ? b1_in : b0_in;
                    ack0_d  = ~win;
                    ack1_d  = win;
                    gnt_d   = win;
                    prio_d  = ~win;
                    cnt_d   = SETTLE_LOAD;
                    busy_d  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    sum_d   = add_s;
                    cout_d  = add_cout;
                    done0_d = ~gnt_q;
                    done1_d = gnt_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            gnt_q   <= 1'b0;
            cnt_q   <= 4'd0;
            add_a_q <= '0;
            add_b_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
        end
    end

    assign add_a    = add_a_q;
    assign add_b    = add_b_q;
    assign sum_out  = sum_q;
    assign cout_out = cout_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter
// Two arbiter instances (settle times 1 and 3) share the same requester
// inputs, each wired to its own behavioural adder. A transaction-level model
// predicts every output each cycle; tables and short hand-written sequences
// add fixed expected values for the documented corner cases.
module tb_adder_share_arbiter;

    localparam int W    = 5;
    localparam int NDUT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;

    logic [W-1:0] add_a [NDUT];
    logic [W-1:0] add_b [NDUT];
    logic [W-1:0] add_s [NDUT];
    logic         add_cout [NDUT];
    logic         ack0 [NDUT];
    logic         ack1 [NDUT];
    logic         done0 [NDUT];
    logic         done1 [NDUT];
    logic [W-1:0] sum_out [NDUT];
    logic         cout_out [NDUT];
    logic         busy [NDUT];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Each instance gets its own stand-in for the board's ripple adder.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        assign {add_cout[g], add_s[g]} = {1'b0, add_a[g]} + {1'b0, add_b[g]};

        adder_share_arbiter #(
            .WIDTH        (W),
            .SETTLE_CYCLES((g == 0) ? 1 : 3)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .req0    (req0),
            .a0_in   (a0),
            .b0_in   (b0),
            .req1    (req1),
            .a1_in   (a1),
            .b1_in   (b1),
            .add_a   (add_a[g]),
            .add_b   (add_b[g]),
            .add_s   (add_s[g]),
            .add_cout(add_cout[g]),
            .ack0    (ack0[g]),
            .ack1    (ack1[g]),
            .done0   (done0[g]),
            .done1   (done1[g]),
            .sum_out (sum_out[g]),
            .cout_out(cout_out[g]),
            .busy    (busy[g])
        );
    end

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit pick(input bit r0, input bit r1, input bit p);
        return (r0 && r1) ? p : r1;
    endfunction

    // Reference model: a transaction is either pending (with the absolute
    // edge number its result is due) or not; grants only when none pending.
    int           m_edge = 0;
    int           m_done_at [NDUT];
    bit           m_pend [NDUT];
    bit           m_who [NDUT];
    bit           m_prio [NDUT];
    bit [W:0]     m_res [NDUT];
    bit [W-1:0]   exp_add_a [NDUT];
    bit [W-1:0]   exp_add_b [NDUT];
    bit [W-1:0]   exp_sum [NDUT];
    bit           exp_cout [NDUT];
    bit           exp_ack0 [NDUT];
    bit           exp_ack1 [NDUT];
    bit           exp_done0 [NDUT];
    bit           exp_done1 [NDUT];
    bit           exp_busy [NDUT];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < NDUT; d++) begin
                m_pend[d]    <= 1'b0;
                m_prio[d]    <= 1'b0;
                exp_add_a[d] <= '0;
                exp_add_b[d] <= '0;
                exp_sum[d]   <= '0;
                exp_cout[d]  <= 1'b0;
                exp_ack0[d]  <= 1'b0;
                exp_ack1[d]  <= 1'b0;
                exp_done0[d] <= 1'b0;
                exp_done1[d] <= 1'b0;
                exp_busy[d]  <= 1'b0;
            end
        end else begin
            m_edge <= m_edge + 1;
            for (int d = 0; d < NDUT; d++) begin
                exp_ack0[d]  <= 1'b0;
                exp_ack1[d]  <= 1'b0;
                exp_done0[d] <= 1'b0;
                exp_done1[d] <= 1'b0;
                if (m_pend[d]) begin
                    if (m_edge + 1 == m_done_at[d]) begin
                        exp_sum[d]   <= m_res[d][W-1:0];
                        exp_cout[d]  <= m_res[d][W];
                        exp_done0[d] <= !m_who[d];
                        exp_done1[d] <= m_who[d];
                        exp_busy[d]  <= 1'b0;
                        m_pend[d]    <= 1'b0;
                    end
                end else if (req0 || req1) begin
                    m_who[d]     <= pick(req0, req1, m_prio[d]);
                    m_prio[d]    <= !pick(req0, req1, m_prio[d]);
                    exp_ack0[d]  <= !pick(req0, req1, m_prio[d]);
                    exp_ack1[d]  <= pick(req0, req1, m_prio[d]);
                    exp_add_a[d] <= pick(req0, req1, m_prio[d]) ? a1 : a0;
                    exp_add_b[d] <= pick(req0, req1, m_prio[d]) ? b1 : b0;
                    m_res[d]     <= pick(req0, req1, m_prio[d]) ?
                                    ({1'b0, a1} + {1'b0, b1}) :
                                    ({1'b0, a0} + {1'b0, b0});
                    m_done_at[d] <= m_edge + 1 + settle_of(d);
                    m_pend[d]    <= 1'b1;
                    exp_busy[d]  <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output of both instances against the model.
    task automatic checkOutput();
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("dut%0d add_a", d), 32'(add_a[d]), 32'(exp_add_a[d]));
            chk($sformatf("dut%0d add_b", d), 32'(add_b[d]), 32'(exp_add_b[d]));
            chk($sformatf("dut%0d ack0", d), 32'(ack0[d]), 32'(exp_ack0[d]));
            chk($sformatf("dut%0d ack1", d), 32'(ack1[d]), 32'(exp_ack1[d]));
            chk($sformatf("dut%0d done0", d), 32'(done0[d]), 32'(exp_done0[d]));
            chk($sformatf("dut%0d done1", d), 32'(done1[d]), 32'(exp_done1[d]));
            chk($sformatf("dut%0d sum_out", d), 32'(sum_out[d]), 32'(exp_sum[d]));
            chk($sformatf("dut%0d cout_out", d), 32'(cout_out[d]), 32'(exp_cout[d]));
            chk($sformatf("dut%0d busy", d), 32'(busy[d]), 32'(exp_busy[d]));
        end
    endtask

    task automatic applyStimulus(input bit r0, input bit [W-1:0] x0, input bit [W-1:0] y0,
                                 input bit r1, input bit [W-1:0] x1, input bit [W-1:0] y1);
        req0 = r0;
        a0   = x0;
        b0   = y0;
        req1 = r1;
        a1   = x1;
        b1   = y1;
    endtask

    // Advance to the next falling edge and check everything there.
    task automatic step();
        @(negedge clk);
        checkOutput();
    endtask

    // Assert reset in the middle of a high phase, check the asynchronous
    // clear, then release it on a falling edge.
    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput();
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("dut%0d async busy", d), 32'(busy[d]), 32'd0);
            chk($sformatf("dut%0d async sum", d), 32'(sum_out[d]), 32'd0);
        end
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        bit         sel;
        bit [W-1:0] a;
        bit [W-1:0] b;
        bit [W-1:0] exp_sum;
        bit         exp_cout;
    } vec_t;

    vec_t       vecs [6];
    int         order [$];
    bit         saw_done1;
    bit [W-1:0] ra, rb, rc, rd;

    initial begin
        vecs[0] = '{1'b0, 5'd13, 5'd9,  5'd22, 1'b0};
        vecs[1] = '{1'b1, 5'd31, 5'd1,  5'd0,  1'b1};
        vecs[2] = '{1'b0, 5'd16, 5'd16, 5'd0,  1'b1};
        vecs[3] = '{1'b1, 5'd7,  5'd8,  5'd15, 1'b0};
        vecs[4] = '{1'b0, 5'd31, 5'd31, 5'd30, 1'b1};
        vecs[5] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0};

        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        step();
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("dut%0d reset busy", d), 32'(busy[d]), 32'd0);
            chk($sformatf("dut%0d reset add_a", d), 32'(add_a[d]), 32'd0);
        end
        step();
        rst = 1'b0;
        step();
        step();

        // Single transactions from the table, one requester at a time.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(!vecs[i].sel, vecs[i].a, vecs[i].b,
                          vecs[i].sel, vecs[i].a, vecs[i].b);
            step();
            chk($sformatf("vec%0d ack", i), 32'({ack1[0], ack0[0]}),
                vecs[i].sel ? 32'd2 : 32'd1);
            applyStimulus(0, 0, 0, 0, 0, 0);
            for (int c = 0; c < 5; c++) step();
            for (int d = 0; d < NDUT; d++) begin
                chk($sformatf("vec%0d dut%0d sum", i, d), 32'(sum_out[d]), 32'(vecs[i].exp_sum));
                chk($sformatf("vec%0d dut%0d cout", i, d), 32'(cout_out[d]), 32'(vecs[i].exp_cout));
            end
        end

        // Contention: both held high, grants alternate starting with 0.
        do_reset();
        applyStimulus(1, 5'd3, 5'd4, 1, 5'd10, 5'd20);
        for (int c = 0; c < 16; c++) begin
            step();
            if (ack0[0]) order.push_back(0);
            if (ack1[0]) order.push_back(1);
            if (done0[0]) chk("contention sum0", 32'(sum_out[0]), 32'd7);
            if (done1[0]) chk("contention sum1", 32'(sum_out[0]), 32'd30);
        end
        chk("contention grant count", 32'(order.size()), 32'd8);
        for (int i = 0; i < order.size() && i < 4; i++)
            chk($sformatf("contention grant%0d", i), 32'(order[i]), 32'(i % 2));

        // Operand stability on the slow instance.
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) step();
        applyStimulus(1, 5'd5, 5'd2, 0, 0, 0);
        step();
        chk("stability ack0", 32'(ack0[1]), 32'd1);
        applyStimulus(0, 5'd20, 5'd2, 0, 0, 0);
        step();
        chk("stability add_a", 32'(add_a[1]), 32'd5);
        step();
        step();
        chk("stability sum", 32'(sum_out[1]), 32'd7);
        chk("stability add_a held", 32'(add_a[1]), 32'd5);

        // Reset during ADD on the slow instance: no done, then 0 wins.
        step();
        applyStimulus(0, 0, 0, 1, 5'd9, 5'd9);
        step();
        chk("abort ack1", 32'(ack1[1]), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        do_reset();
        saw_done1 = 1'b0;
        applyStimulus(1, 5'd1, 5'd2, 1, 5'd4, 5'd4);
        step();
        chk("abort first grant ack0", 32'(ack0[1]), 32'd1);
        chk("abort first grant ack1", 32'(ack1[1]), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            if (done1[1]) saw_done1 = 1'b1;
        end
        chk("abort no done1", 32'(saw_done1), 32'd0);
        chk("abort result", 32'(sum_out[1]), 32'd3);

        // Randomized traffic including occasional resets.
        for (int c = 0; c < 400; c++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = W'($urandom);
            rd = W'($urandom);
            applyStimulus($urandom_range(0, 2) != 0, ra, rb, $urandom_range(0, 2) != 0, rc, rd);
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
